avm_pio_poll_master: RTL and testbench

- Avalon-MM read master: the initiator side for the single-register PIO input slaves (e.g. the 3-bit ADC channel PIO).
- Periodically reads one slave address with fixed read latency.
- Detects changes in the low DATA_W bits and queues each change in a small FIFO with valid/ready output.
- Lets fabric logic track PIO inputs without the NIOS II polling them.

---
 rtl/avm_pio_poll_pkg.sv | 19 +
 rtl/avm_pio_poll_fifo.sv | 58 +++++
 rtl/avm_pio_poll_master.sv | 141 ++++++++++++++
 tb/tb_avm_pio_poll_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_pio_poll_pkg.sv
// Shared types and constants for the Avalon-MM PIO poll master.
// Optional timestamp support is enabled with AVM_PIO_POLL_TIMESTAMP_EN.
package avm_pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_t;

  localparam int TS_W = 16;

  // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/avm_pio_poll_fifo.sv
// Small synchronous FIFO with flop-based head, simultaneous push/pop and level output.
module avm_pio_poll_fifo
  import avm_pio_poll_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  // NOTE: storage has no reset; the empty gate on rdata hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avm_pio_poll_master.sv
// Avalon-MM read master that polls one PIO register and queues value changes.
// Define AVM_PIO_POLL_TIMESTAMP_EN to attach a 16-bit capture timestamp to each entry.
module avm_pio_poll_master
  import avm_pio_poll_pkg::*;
#(
  parameter int DATA_W       = 3,
  parameter int ADDR_W       = 2,
  parameter int POLL_DIV     = 1000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [ADDR_W-1:0]              poll_addr,
  output logic [ADDR_W-1:0]              avm_address,
  output logic                           avm_read,
  input  logic [31:0]                    avm_readdata,
  output logic [DATA_W-1:0]              cur_value,
  output logic                           chg_valid,
  input  logic                           chg_ready,
  output logic [DATA_W-1:0]              chg_data,
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
  output logic [TS_W-1:0]                chg_timestamp,
`endif
  output logic [level_w(FIFO_DEPTH)-1:0] chg_level,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  localparam int DIV_W      = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_LAST_I = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
  localparam int FIFO_W     = DATA_W + TS_W;
`else
  localparam int FIFO_W     = DATA_W;
`endif

  poll_state_t        state;
  poll_state_t        state_n;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         lat_cnt;
  logic               tick;
  logic               seen;
  logic [DATA_W-1:0]  sample;
  logic               push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_W-1:0]  fifo_wdata;
  logic [FIFO_W-1:0]  fifo_rdata;
  logic               unused_upper;

  assign sample       = avm_readdata[DATA_W-1:0];
  assign unused_upper = ^avm_readdata[31:DATA_W];
  assign tick         = enable && (state == IDLE) && (div_cnt == DIV_W'(POLL_DIV - 1));
  assign push         = (state == CAPTURE) && (!seen || (sample != cur_value));
  assign fifo_pop     = chg_valid && chg_ready;
  assign chg_valid    = !fifo_empty;
  assign avm_read     = (state == READ);
  assign avm_address  = (state == READ) ? poll_addr : '0;

  // Divider only runs between transactions, so the poll period is POLL_DIV plus the bus cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_n;
      lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  // NOTE: defaults first keep every path assigned, so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = READ;
      READ:    state_n = (READ_LATENCY == 1) ? CAPTURE : WAIT;
      WAIT:    if (lat_cnt == 2'(LAT_LAST_I)) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // cur_value follows every change even when the FIFO drops the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_value <= '0;
      seen      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) cur_value <= sample;
      if (state == CAPTURE)               seen <= 1'b1;
      else if (!enable && state == IDLE)  seen <= 1'b0;
      if (push && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (overflow_clr)              overflow <= 1'b0;
    end
  end

`ifdef AVM_PIO_POLL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign fifo_wdata    = {ts_cnt, sample};
  assign chg_timestamp = fifo_rdata[FIFO_W-1:DATA_W];
`else
  assign fifo_wdata    = sample;
`endif
  assign chg_data      = fifo_rdata[DATA_W-1:0];

  avm_pio_poll_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (chg_level)
  );

endmodule

// File: tb/tb_avm_pio_poll_master.sv
// Directed bench for avm_pio_poll_master: one instance with READ_LATENCY=1, one with 3.
module tb_avm_pio_poll_master;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        enable, enable3;
  logic [1:0]  poll_addr, poll_addr3;
  logic [1:0]  avm_address, avm_address3;
  logic        avm_read, avm_read3;
  logic [31:0] avm_readdata, avm_readdata3;
  logic [2:0]  cur_value, cur_value3;
  logic        chg_valid, chg_valid3;
  logic        chg_ready, chg_ready3;
  logic [2:0]  chg_data, chg_data3;
  logic [2:0]  chg_level, chg_level3;
  logic        overflow, overflow3;
  logic        overflow_clr, overflow_clr3;
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
  logic [15:0] chg_timestamp, chg_timestamp3;
  logic [15:0] ts_a, ts_b;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avm_pio_poll_master #(
    .DATA_W(3), .ADDR_W(2), .POLL_DIV(8), .READ_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .poll_addr(poll_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .cur_value(cur_value), .chg_valid(chg_valid), .chg_ready(chg_ready),
    .chg_data(chg_data),
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
    .chg_timestamp(chg_timestamp),
`endif
    .chg_level(chg_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  avm_pio_poll_master #(
    .DATA_W(3), .ADDR_W(2), .POLL_DIV(8), .READ_LATENCY(3), .FIFO_DEPTH(4)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable3), .poll_addr(poll_addr3),
    .avm_address(avm_address3), .avm_read(avm_read3), .avm_readdata(avm_readdata3),
    .cur_value(cur_value3), .chg_valid(chg_valid3), .chg_ready(chg_ready3),
    .chg_data(chg_data3),
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
    .chg_timestamp(chg_timestamp3),
`endif
    .chg_level(chg_level3), .overflow(overflow3), .overflow_clr(overflow_clr3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next avm_read cycle; returns the cycle count when seen.
  task automatic wait_read(input bit on3, input string tag, output int at);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = on3 ? avm_read3 : avm_read;
    end
    at = cyc;
    if (!hit) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no avm_read within 100 cycles, expected a read", tag);
    end
  endtask

  // One full poll on the latency-1 instance; ends at the negedge after CAPTURE.
  task automatic poll(input logic [2:0] val, input bit ready_on_cap, input string tag,
                      output int at);
    avm_readdata = 32'hDEAD_BEE8 | 32'(val);
    wait_read(1'b0, tag, at);
    check({tag, " addr"}, 32'(avm_address), 32'd2);
    @(negedge clk);
    if (ready_on_cap) chg_ready = 1'b1;
    @(negedge clk);
    if (ready_on_cap) chg_ready = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, reads;
    logic [2:0] drain_exp [4];

    reset_n = 1'b0;
    enable = 1'b0;        enable3 = 1'b0;
    poll_addr = 2'd2;     poll_addr3 = 2'd1;
    avm_readdata = '0;    avm_readdata3 = '0;
    chg_ready = 1'b0;     chg_ready3 = 1'b0;
    overflow_clr = 1'b0;  overflow_clr3 = 1'b0;

    // Reset state
    #12;
    check("rst avm_read",  32'(avm_read),    32'd0);
    check("rst avm_addr",  32'(avm_address), 32'd0);
    check("rst cur_value", 32'(cur_value),   32'd0);
    check("rst chg_valid", 32'(chg_valid),   32'd0);
    check("rst chg_data",  32'(chg_data),    32'd0);
    check("rst chg_level", 32'(chg_level),   32'd0);
    check("rst overflow",  32'(overflow),    32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("disabled no read", 32'(avm_read), 32'd0);

    // Constant 0x5: one push, then silence; reads every 10 cycles
    avm_readdata = 32'hFFFF_FFF5;
    @(posedge clk);
    #1 enable = 1'b1;
    t0 = cyc;
    wait_read(1'b0, "first read", t1);
    check("first read delay", 32'(t1 - t0), 32'd8);
    check("first read addr", 32'(avm_address), 32'd2);
    @(negedge clk);
    check("read one cycle", 32'(avm_read), 32'd0);
    check("addr zero outside read", 32'(avm_address), 32'd0);
    @(negedge clk);
    check("first push valid", 32'(chg_valid), 32'd1);
    check("first push data",  32'(chg_data),  32'd5);
    check("first cur_value",  32'(cur_value), 32'd5);
    check("first level",      32'(chg_level), 32'd1);
    poll(3'd5, 1'b0, "same value", t2);
    check("poll period", 32'(t2 - t1), 32'd10);
    check("no push unchanged", 32'(chg_level), 32'd1);
    chg_ready = 1'b1;
    @(negedge clk) chg_ready = 1'b0;
    check("pop level", 32'(chg_level), 32'd0);
    check("pop valid", 32'(chg_valid), 32'd0);

    // Changes 0x2 then 0x7 with consumer always ready
    chg_ready = 1'b1;
    poll(3'd2, 1'b0, "chg 2", t1);
    check("chg 2 data", 32'(chg_data),  32'd2);
    check("chg 2 cur",  32'(cur_value), 32'd2);
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
    ts_a = chg_timestamp;
`endif
    @(negedge clk);
    check("chg 2 popped", 32'(chg_valid), 32'd0);
    poll(3'd7, 1'b0, "chg 7", t1);
    check("chg 7 data",     32'(chg_data),  32'd7);
    check("chg 7 cur",      32'(cur_value), 32'd7);
    check("chg 7 overflow", 32'(overflow),  32'd0);
`ifdef AVM_PIO_POLL_TIMESTAMP_EN
    ts_b = chg_timestamp;
    check("timestamp delta", 32'(16'(ts_b - ts_a)), 32'd10);
`endif
    @(negedge clk);
    check("chg 7 popped", 32'(chg_valid), 32'd0);
    chg_ready = 1'b0;

    // Fill with six changes; clear held during the 6th drop loses to the set
    for (int v = 1; v <= 6; v++) begin
      if (v == 6) overflow_clr = 1'b1;
      poll(3'(v), 1'b0, "fill", t1);
      check("fill level",    32'(chg_level), (v < 4) ? 32'(v) : 32'd4);
      check("fill cur",      32'(cur_value), 32'(v));
      check("fill overflow", 32'(overflow),  (v >= 5) ? 32'd1 : 32'd0);
      check("fill head",     32'(chg_data),  32'd1);
      overflow_clr = 1'b0;
    end
    overflow_clr = 1'b1;
    @(negedge clk) overflow_clr = 1'b0;
    check("overflow cleared", 32'(overflow),  32'd0);
    check("level after clr",  32'(chg_level), 32'd4);

    // Full FIFO with pop on the capture cycle: swap, no overflow
    poll(3'd0, 1'b1, "full swap", t1);
    check("swap level",    32'(chg_level), 32'd4);
    check("swap overflow", 32'(overflow),  32'd0);
    check("swap cur",      32'(cur_value), 32'd0);
    drain_exp = '{3'd2, 3'd3, 3'd4, 3'd0};
    chg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain data", 32'(chg_data), 32'(drain_exp[i]));
      @(negedge clk);
    end
    check("drain empty", 32'(chg_valid), 32'd0);
    check("drain level", 32'(chg_level), 32'd0);
    chg_ready = 1'b0;
    enable = 1'b0;

    // READ_LATENCY=3: enable drops in WAIT; data valid only 3 cycles after READ
    avm_readdata3 = 32'h0000_0006;
    enable3 = 1'b1;
    wait_read(1'b1, "l3 read", t1);
    check("l3 addr", 32'(avm_address3), 32'd1);
    @(negedge clk);
    enable3 = 1'b0;
    check("l3 wait1 no push", 32'(chg_valid3), 32'd0);
    @(negedge clk);
    check("l3 wait2 no push", 32'(chg_valid3), 32'd0);
    @(negedge clk);
    avm_readdata3 = 32'hFFFF_FFFB;
    check("l3 capture no push yet", 32'(chg_valid3), 32'd0);
    @(negedge clk);
    avm_readdata3 = 32'h0000_0006;
    check("l3 push valid", 32'(chg_valid3), 32'd1);
    check("l3 push data",  32'(chg_data3),  32'd3);
    check("l3 cur",        32'(cur_value3), 32'd3);
    reads = 0;
    repeat (30) begin
      @(negedge clk);
      if (avm_read3) reads++;
    end
    check("l3 no read disabled", 32'(reads), 32'd0);
    avm_readdata3 = 32'h0000_0003;
    enable3 = 1'b1;
    wait_read(1'b1, "l3 reenable", t1);
    repeat (4) @(negedge clk);
    check("l3 reenable pushes", 32'(chg_level3), 32'd2);
    check("l3 reenable cur",    32'(cur_value3), 32'd3);

    // Reset during WAIT: immediate clear, next read a full divider period later
    wait_read(1'b1, "l3 pre reset", t1);
    @(negedge clk);
    reset_n = 1'b0;
    avm_readdata3 = 32'h0000_0005;
    #1;
    check("mid rst avm_read",  32'(avm_read3),    32'd0);
    check("mid rst avm_addr",  32'(avm_address3), 32'd0);
    check("mid rst cur",       32'(cur_value3),   32'd0);
    check("mid rst valid",     32'(chg_valid3),   32'd0);
    check("mid rst data",      32'(chg_data3),    32'd0);
    check("mid rst level",     32'(chg_level3),   32'd0);
    check("mid rst overflow",  32'(overflow3),    32'd0);
    @(negedge clk) reset_n = 1'b1;
    t0 = cyc;
    wait_read(1'b1, "post reset read", t1);
    check("post reset delay", 32'(t1 - t0), 32'd8);
    check("post reset no push", 32'(chg_valid3), 32'd0);
    repeat (4) @(negedge clk);
    check("post reset push", 32'(chg_valid3), 32'd1);
    check("post reset cur",  32'(cur_value3), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
